// File: rtl/add_pipe_if.sv
// Handshake bundle for the pipelined adder: operand side (in_*) and result side (out_*).
interface add_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, en, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, en, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined adder: one SW-bit slice per stage, ripple carry registered between stages,
// bubble-collapsing valid/ready flow control. WIDTH must be a multiple of STAGES (STAGES >= 2).
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    add_pipe_if.slave   io
);
    localparam int SW = WIDTH / STAGES;

    // Inner stages 0..STAGES-2 hold skewed operands, partial result, carry and en.
    logic [STAGES-1:0] v_r;
    logic [WIDTH-1:0]  a_r   [STAGES-1];
    logic [WIDTH-1:0]  b_r   [STAGES-1];
    logic [WIDTH-1:0]  res_r [STAGES-1];
    logic [STAGES-2:0] c_r;
    logic [STAGES-2:0] en_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovf_r;

    logic [STAGES-1:0] ld_s;
    logic [STAGES:0]   take_s;
    logic [STAGES-1:0] up_v_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_res_s [STAGES];
    logic [WIDTH-1:0]  nres_s    [STAGES];
    logic [STAGES-1:0] src_c_s;
    logic [STAGES-1:0] src_en_s;
    logic [STAGES-1:0] nc_s;
    logic [SW:0]       slice_s;

    // Signed overflow from operand and result sign bits (equivalent to carry-in ^ carry-out of the MSB).
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

    // Ready chain, walked from the output back to the input; take_s[k] = stage k captures this cycle.
    always_comb begin
        up_v_s         = {v_r[STAGES-2:0], io.in_valid};
        ld_s           = '0;
        take_s         = '0;
        take_s[STAGES] = io.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld_s[k]   = ~v_r[k] | take_s[k + 1];
            take_s[k] = ld_s[k] & up_v_s[k];
        end
    end

    // Per-stage slice addition; stage 0 reads the ports, later stages read the previous stage.
    always_comb begin
        src_a_s[0]   = io.a;
        src_b_s[0]   = io.b;
        src_res_s[0] = '0;
        src_c_s[0]   = io.cin;
        src_en_s[0]  = io.en;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = a_r[k - 1];
            src_b_s[k]   = b_r[k - 1];
            src_res_s[k] = res_r[k - 1];
            src_c_s[k]   = c_r[k - 1];
            src_en_s[k]  = en_r[k - 1];
        end
        slice_s = '0;
        nc_s    = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_s = {1'b0, src_a_s[k][k*SW +: SW]} + {1'b0, src_b_s[k][k*SW +: SW]}
                    + {{SW{1'b0}}, src_c_s[k]};
            nres_s[k]              = src_res_s[k];
            nres_s[k][k*SW +: SW]  = slice_s[SW-1:0];
            nc_s[k]                = slice_s[SW];
        end
    end

    // Stage registers; data only moves on a capture, so idle outputs keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r    <= '0;
            c_r    <= '0;
            en_r   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    v_r[k] <= up_v_s[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (take_s[k]) begin
                    a_r[k]   <= src_a_s[k];
                    b_r[k]   <= src_b_s[k];
                    res_r[k] <= nres_s[k];
                    c_r[k]   <= nc_s[k];
                    en_r[k]  <= src_en_s[k];
                end
            end
            if (take_s[STAGES-1]) begin
                if (src_en_s[STAGES-1]) begin
                    sum_r  <= nres_s[STAGES-1];
                    cout_r <= nc_s[STAGES-1];
                    ovf_r  <= ovf_f(src_a_s[STAGES-1][WIDTH-1], src_b_s[STAGES-1][WIDTH-1],
                                    nres_s[STAGES-1][WIDTH-1]);
                end else begin
                    sum_r  <= '0;
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                end
            end
        end
    end

    assign io.in_ready  = ld_s[0];
    assign io.out_valid = v_r[STAGES-1];
    assign io.sum       = sum_r;
    assign io.cout      = cout_r;
    assign io.overflow  = ovf_r;
endmodule
